// File: rtl/axi_rom_arbiter.sv
// Two-master AXI4 read arbiter in front of the boot ROM; one read outstanding,
// and writes are answered locally with an error response so the ROM never sees them.
package axi_rom_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi_error_t;

  typedef struct packed {
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic [ID_W-1:0]   bid;
    axi_error_t        bresp;
    logic              bvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
  } s_axi_miso_t;
endpackage

module axi_rom_wr_term
  import axi_rom_pkg::*;
#(
  parameter axi_error_t WR_RESP = SLVERR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            awvalid,
  input  logic [ID_W-1:0] awid,
  input  logic            wvalid,
  input  logic            wlast,
  input  logic            bready,
  output logic            awready,
  output logic            wready,
  output logic            bvalid,
  output logic [ID_W-1:0] bid,
  output axi_error_t      bresp
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  wr_state_t       state, state_nx;
  logic [ID_W-1:0] id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= W_IDLE;
      id_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == W_IDLE && awvalid) id_q <= awid;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      W_IDLE:  if (awvalid) state_nx = W_DATA;
      W_DATA:  if (wvalid && wlast) state_nx = W_RESP;
      W_RESP:  if (bready) state_nx = W_IDLE;
      default: state_nx = W_IDLE;
    endcase
  end

  // awready is masked during reset so no handshake is advertised while held.
  always_comb begin
    awready = (state == W_IDLE) && !rst;
    wready  = (state == W_DATA);
    bvalid  = (state == W_RESP);
    bid     = id_q;
    bresp   = WR_RESP;
  end
endmodule

module axi_rom_arbiter
  import axi_rom_pkg::*;
#(
  parameter bit         RR_EN   = 1'b1,
  parameter axi_error_t WR_RESP = SLVERR
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t m0_axi_mosi,
  output s_axi_miso_t m0_axi_miso,
  input  s_axi_mosi_t m1_axi_mosi,
  output s_axi_miso_t m1_axi_miso,
  output s_axi_mosi_t s_axi_mosi,
  input  s_axi_miso_t s_axi_miso
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_state_t;
  rd_state_t   state, state_nx;
  logic        grant, grant_nx;
  logic        prio_ptr, prio_nx;
  s_axi_mosi_t gm;
  s_axi_mosi_t mosi_v [2];
  logic        wr_awready [2];
  logic        wr_wready  [2];
  logic        wr_bvalid  [2];
  logic [ID_W-1:0] wr_bid [2];
  axi_error_t  wr_bresp   [2];
  logic        unused_ok;

  assign gm        = grant ? m1_axi_mosi : m0_axi_mosi;
  assign mosi_v[0] = m0_axi_mosi;
  assign mosi_v[1] = m1_axi_mosi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio_ptr <= 1'b0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      prio_ptr <= prio_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    prio_nx  = prio_ptr;
    case (state)
      IDLE: if (m0_axi_mosi.arvalid || m1_axi_mosi.arvalid) begin
        state_nx = ADDR;
        if (m0_axi_mosi.arvalid && m1_axi_mosi.arvalid) grant_nx = RR_EN ? prio_ptr : 1'b0;
        else                                            grant_nx = m1_axi_mosi.arvalid;
      end
      // A master withdrawing arvalid before the handshake is dropped, not forwarded.
      ADDR: if (!gm.arvalid)             state_nx = IDLE;
            else if (s_axi_miso.arready) state_nx = DATA;
      DATA: if (s_axi_miso.rvalid && gm.rready && s_axi_miso.rlast) begin
        state_nx = IDLE;
        if (RR_EN) prio_nx = ~grant;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axi_mosi         = '0;
    s_axi_mosi.arid    = gm.arid;
    s_axi_mosi.araddr  = gm.araddr;
    s_axi_mosi.arlen   = gm.arlen;
    s_axi_mosi.arsize  = gm.arsize;
    s_axi_mosi.arburst = gm.arburst;
    s_axi_mosi.arvalid = (state == ADDR) && gm.arvalid;
    s_axi_mosi.rready  = (state == DATA) && gm.rready;

    m0_axi_miso = '0;
    m1_axi_miso = '0;
    if (state == ADDR) begin
      if (grant) m1_axi_miso.arready = s_axi_miso.arready;
      else       m0_axi_miso.arready = s_axi_miso.arready;
    end
    if (state == DATA) begin
      if (grant) begin
        m1_axi_miso.rid    = s_axi_miso.rid;
        m1_axi_miso.rdata  = s_axi_miso.rdata;
        m1_axi_miso.rresp  = s_axi_miso.rresp;
        m1_axi_miso.rlast  = s_axi_miso.rlast;
        m1_axi_miso.rvalid = s_axi_miso.rvalid;
      end else begin
        m0_axi_miso.rid    = s_axi_miso.rid;
        m0_axi_miso.rdata  = s_axi_miso.rdata;
        m0_axi_miso.rresp  = s_axi_miso.rresp;
        m0_axi_miso.rlast  = s_axi_miso.rlast;
        m0_axi_miso.rvalid = s_axi_miso.rvalid;
      end
    end
    m0_axi_miso.awready = wr_awready[0];
    m0_axi_miso.wready  = wr_wready[0];
    m0_axi_miso.bvalid  = wr_bvalid[0];
    m0_axi_miso.bid     = wr_bid[0];
    m0_axi_miso.bresp   = wr_bresp[0];
    m1_axi_miso.awready = wr_awready[1];
    m1_axi_miso.wready  = wr_wready[1];
    m1_axi_miso.bvalid  = wr_bvalid[1];
    m1_axi_miso.bid     = wr_bid[1];
    m1_axi_miso.bresp   = wr_bresp[1];
  end

  for (genvar i = 0; i < 2; i++) begin : g_wr
    axi_rom_wr_term #(.WR_RESP(WR_RESP)) u_wr (
      .clk     (clk),
      .rst     (rst),
      .awvalid (mosi_v[i].awvalid),
      .awid    (mosi_v[i].awid),
      .wvalid  (mosi_v[i].wvalid),
      .wlast   (mosi_v[i].wlast),
      .bready  (mosi_v[i].bready),
      .awready (wr_awready[i]),
      .wready  (wr_wready[i]),
      .bvalid  (wr_bvalid[i]),
      .bid     (wr_bid[i]),
      .bresp   (wr_bresp[i])
    );
  end

  // Write payloads and the ROM's B channel are intentionally discarded.
  assign unused_ok = ^{m0_axi_mosi.awaddr, m0_axi_mosi.awlen, m0_axi_mosi.awsize, m0_axi_mosi.awburst,
                       m0_axi_mosi.wdata, m0_axi_mosi.wstrb,
                       m1_axi_mosi.awaddr, m1_axi_mosi.awlen, m1_axi_mosi.awsize, m1_axi_mosi.awburst,
                       m1_axi_mosi.wdata, m1_axi_mosi.wstrb,
                       s_axi_miso.awready, s_axi_miso.wready, s_axi_miso.bid, s_axi_miso.bresp,
                       s_axi_miso.bvalid};
endmodule

// File: tb/tb_axi_rom_arbiter.sv
// Bench: two arbiters (round-robin and fixed priority) each in front of a behavioural ROM slave.
module tb_axi_rom_arbiter;
  import axi_rom_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   ptr0 = 0;

  s_axi_mosi_t mm [2][2];
  s_axi_miso_t ms [2][2];
  s_axi_mosi_t sm [2];
  s_axi_miso_t ss [2];
  bit          fast [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  axi_rom_arbiter #(.RR_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .m0_axi_mosi(mm[0][0]), .m0_axi_miso(ms[0][0]),
    .m1_axi_mosi(mm[0][1]), .m1_axi_miso(ms[0][1]),
    .s_axi_mosi(sm[0]), .s_axi_miso(ss[0]));

  axi_rom_arbiter #(.RR_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .m0_axi_mosi(mm[1][0]), .m0_axi_miso(ms[1][0]),
    .m1_axi_mosi(mm[1][1]), .m1_axi_miso(ms[1][1]),
    .s_axi_mosi(sm[1]), .s_axi_miso(ss[1]));

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  // ROM slave: INCR bursts, one beat per accepted rready, optional random arready.
  for (genvar k = 0; k < 2; k++) begin : g_rom
    logic        busy, rdy;
    logic [31:0] ra;
    logic [3:0]  rid;
    logic [7:0]  rem;
    int          leaks = 0;
    s_axi_miso_t rsp;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy <= 1'b0; rdy <= 1'b0; ra <= '0; rid <= '0; rem <= '0;
      end else begin
        rdy <= fast[k] ? 1'b1 : 1'($urandom_range(0, 1));
        if (!busy && sm[k].arvalid && rsp.arready) begin
          busy <= 1'b1; ra <= sm[k].araddr; rid <= sm[k].arid; rem <= sm[k].arlen;
        end else if (busy && sm[k].rready) begin
          if (rem == 0) busy <= 1'b0;
          else begin rem <= rem - 1; ra <= ra + 4; end
        end
      end
    end
    always_comb begin
      rsp         = '0;
      rsp.arready = !busy && rdy;
      rsp.rvalid  = busy;
      rsp.rdata   = rom_word(ra);
      rsp.rid     = rid;
      rsp.rlast   = (rem == 0);
      rsp.bvalid  = 1'b1;
      rsp.bresp   = OKAY;
    end
    assign ss[k] = rsp;
    always @(negedge clk) if (sm[k].awvalid || sm[k].wvalid || sm[k].bready) leaks++;
  end

  task automatic wait_sig(input int k, input int m, input int which, output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      case (which)
        0: ok = ms[k][m].arready;
        1: ok = ms[k][m].rvalid;
        2: ok = ms[k][m].awready;
        3: ok = ms[k][m].wready;
        default: ok = ms[k][m].bvalid;
      endcase
      if (ok) break;
    end
  endtask

  task automatic rd(input int k, input int m, input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input int stall, output int t_hs, output int nb,
                    output logic [31:0] dat [8], output logic [3:0] rids [8], output logic [7:0] lasts);
    bit ok, done;
    int sc;
    nb = 0; t_hs = -1; lasts = '0; done = 1'b0; sc = 0;
    for (int i = 0; i < 8; i++) begin dat[i] = '0; rids[i] = '0; end
    @(posedge clk); #1;
    mm[k][m].arid = id; mm[k][m].araddr = a; mm[k][m].arlen = len;
    mm[k][m].arsize = 3'd2; mm[k][m].arburst = 2'd1; mm[k][m].arvalid = 1'b1; mm[k][m].rready = 1'b0;
    wait_sig(k, m, 0, ok);
    if (ok) t_hs = cyc;
    @(posedge clk); #1;
    mm[k][m].arvalid = 1'b0;
    if (!ok) return;
    for (int w = 0; w < 200 && !done; w++) begin
      if (sc >= stall) mm[k][m].rready = 1'b1;
      @(negedge clk);
      if (ms[k][m].rvalid) begin
        sc++;
        if (mm[k][m].rready) begin
          if (nb < 8) begin dat[nb] = ms[k][m].rdata; rids[nb] = ms[k][m].rid; lasts[nb] = ms[k][m].rlast; end
          nb++;
          if (ms[k][m].rlast) done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    mm[k][m].rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ({ms[k][m].arready, ms[k][m].rvalid, ms[k][m].awready, ms[k][m].wready, ms[k][m].bvalid} !== 5'b0) begin
          fails++;
          $display("FAIL reset_miso dut%0d m%0d got %b want 00000", k, m,
                   {ms[k][m].arready, ms[k][m].rvalid, ms[k][m].awready, ms[k][m].wready, ms[k][m].bvalid});
        end
      end
      checks++;
      if ({sm[k].arvalid, sm[k].rready, sm[k].awvalid, sm[k].wvalid} !== 4'b0) begin
        fails++; $display("FAIL reset_s_mosi dut%0d got %b want 0000", k, {sm[k].arvalid, sm[k].rready, sm[k].awvalid, sm[k].wvalid});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ({ms[k][m].awready, ms[k][m].arready} !== 2'b10) begin
          fails++; $display("FAIL post_reset_ready dut%0d m%0d got %b want 10", k, m, {ms[k][m].awready, ms[k][m].arready});
        end
      end
    end
  endtask

  task automatic test_basic_read();
    @(posedge clk); #1;
    mm[0][0].araddr = 32'h4; mm[0][0].arid = 4'd3; mm[0][0].arlen = 8'd0;
    mm[0][0].arvalid = 1'b1; mm[0][0].rready = 1'b1;
    @(negedge clk);
    checks++;
    if (sm[0].arvalid !== 1'b0) begin fails++; $display("FAIL basic_no_fwd_same_cycle got %b want 0", sm[0].arvalid); end
    @(negedge clk);
    checks++;
    if ({sm[0].arvalid, sm[0].araddr, sm[0].arid, ms[0][0].arready} !== {1'b1, 32'h4, 4'd3, 1'b1}) begin
      fails++; $display("FAIL basic_fwd got v=%b a=%h id=%0d rdy=%b want 1 00000004 3 1",
                        sm[0].arvalid, sm[0].araddr, sm[0].arid, ms[0][0].arready);
    end
    @(posedge clk); #1;
    mm[0][0].arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ms[0][0].rvalid, ms[0][0].rid, ms[0][0].rlast, ms[0][0].rdata} !== {1'b1, 4'd3, 1'b1, rom_word(32'h4)}) begin
      fails++; $display("FAIL basic_resp got v=%b id=%0d last=%b d=%h want 1 3 1 %h",
                        ms[0][0].rvalid, ms[0][0].rid, ms[0][0].rlast, ms[0][0].rdata, rom_word(32'h4));
    end
    checks++;
    if (ms[0][1].rvalid !== 1'b0) begin fails++; $display("FAIL basic_m1_quiet got %b want 0", ms[0][1].rvalid); end
    @(posedge clk); #1;
    mm[0][0].rready = 1'b0;
    ptr0 = 1;
  endtask

  task automatic test_round_robin();
    int t0, t1, n0, n1, kind, st0, st1, win, exp_win;
    logic [31:0] a0, a1;
    logic [3:0]  id0, id1;
    logic [7:0]  len0, len1, l0, l1;
    logic [31:0] d0 [8], d1 [8];
    logic [3:0]  i0 [8], i1 [8];
    bit ok;
    for (int k = 0; k < 2; k++) begin
      fast[k] = 1'b0;
      for (int r = 0; r < 10; r++) begin
        kind = (r < 2) ? 2 : $urandom_range(0, 2);
        a0 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}; a1 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        id0 = 4'($urandom_range(0, 15)); id1 = 4'($urandom_range(0, 15));
        len0 = 8'($urandom_range(0, 3)); len1 = 8'($urandom_range(0, 3));
        st0 = $urandom_range(0, 2); st1 = $urandom_range(0, 2);
        t0 = -1; t1 = -1;
        fork
          begin if (kind != 1) rd(k, 0, a0, id0, len0, st0, t0, n0, d0, i0, l0); end
          begin if (kind != 0) rd(k, 1, a1, id1, len1, st1, t1, n1, d1, i1, l1); end
        join
        if (kind != 1) begin
          ok = (n0 == int'(len0) + 1) && (t0 >= 0);
          for (int i = 0; i <= int'(len0); i++)
            if (d0[i] !== rom_word(a0 + 32'(4 * i)) || i0[i] !== id0 || l0[i] !== (i == int'(len0))) ok = 1'b0;
          checks++;
          if (!ok) begin fails++; $display("FAIL rr_m0_data dut%0d round%0d beats=%0d want %0d d0=%h want %h", k, r, n0, len0 + 1, d0[0], rom_word(a0)); end
        end
        if (kind != 0) begin
          ok = (n1 == int'(len1) + 1) && (t1 >= 0);
          for (int i = 0; i <= int'(len1); i++)
            if (d1[i] !== rom_word(a1 + 32'(4 * i)) || i1[i] !== id1 || l1[i] !== (i == int'(len1))) ok = 1'b0;
          checks++;
          if (!ok) begin fails++; $display("FAIL rr_m1_data dut%0d round%0d beats=%0d want %0d d0=%h want %h", k, r, n1, len1 + 1, d1[0], rom_word(a1)); end
        end
        if (kind == 2) begin
          win = (t0 < t1) ? 0 : 1;
          exp_win = (k == 0) ? ptr0 : 0;
          checks++;
          if (win !== exp_win) begin fails++; $display("FAIL rr_winner dut%0d round%0d got m%0d want m%0d", k, r, win, exp_win); end
          if (k == 0) ptr0 = win;
        end else if (k == 0) begin
          ptr0 = (kind == 0) ? 1 : 0;
        end
      end
      fast[k] = 1'b1;
    end
  endtask

  task automatic test_rready_stall();
    logic [31:0] a1, a0, d0h;
    int t, n; logic [31:0] d [8]; logic [3:0] ids [8]; logic [7:0] ls;
    bit ok;
    a1 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    a0 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    @(posedge clk); #1;
    mm[0][1].araddr = a1; mm[0][1].arid = 4'd9; mm[0][1].arlen = 8'd0; mm[0][1].arvalid = 1'b1; mm[0][1].rready = 1'b0;
    @(posedge clk); #1;
    mm[0][0].araddr = a0; mm[0][0].arid = 4'd1; mm[0][0].arlen = 8'd0; mm[0][0].arvalid = 1'b1;
    wait_sig(0, 1, 0, ok);
    @(posedge clk); #1;
    mm[0][1].arvalid = 1'b0;
    wait_sig(0, 1, 1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL stall_rvalid_timeout got 0 want 1"); end
    d0h = ms[0][1].rdata;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({sm[0].rready, ms[0][1].rvalid, ms[0][0].arready, ms[0][1].rdata} !== {1'b0, 1'b1, 1'b0, rom_word(a1)} || ms[0][1].rdata !== d0h) begin
        fails++; $display("FAIL stall_hold cyc%0d got srr=%b rv=%b m0rdy=%b d=%h want 0 1 0 %h",
                          c, sm[0].rready, ms[0][1].rvalid, ms[0][0].arready, ms[0][1].rdata, rom_word(a1));
      end
    end
    @(posedge clk); #1;
    mm[0][1].rready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ms[0][1].rvalid, ms[0][1].rlast, sm[0].rready} !== 3'b111) begin
      fails++; $display("FAIL stall_release got %b want 111", {ms[0][1].rvalid, ms[0][1].rlast, sm[0].rready});
    end
    @(posedge clk); #1;
    mm[0][1].rready = 1'b0;
    rd(0, 0, a0, 4'd1, 8'd0, 0, t, n, d, ids, ls);
    checks++;
    if (n !== 1 || d[0] !== rom_word(a0)) begin fails++; $display("FAIL stall_m0_after beats=%0d d=%h want 1 %h", n, d[0], rom_word(a0)); end
    ptr0 = 1;
  endtask

  task automatic test_write_error();
    logic [31:0] a1; logic [3:0] wid; int nbeats;
    int t, n; logic [31:0] d [8]; logic [3:0] ids [8]; logic [7:0] ls;
    bit ok;
    a1 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    wid = 4'($urandom_range(0, 15)); nbeats = $urandom_range(1, 4);
    fork
      begin
        @(posedge clk); #1;
        mm[0][0].awid = 4'd2; mm[0][0].awvalid = 1'b1; mm[0][0].wvalid = 1'b1; mm[0][0].wlast = 1'b1; mm[0][0].bready = 1'b0;
        @(negedge clk);
        checks++;
        if ({ms[0][0].awready, ms[0][0].wready} !== 2'b10) begin fails++; $display("FAIL wr_aw_first got %b want 10", {ms[0][0].awready, ms[0][0].wready}); end
        @(posedge clk); #1;
        mm[0][0].awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ms[0][0].wready !== 1'b1) begin fails++; $display("FAIL wr_w_next got %b want 1", ms[0][0].wready); end
        @(posedge clk); #1;
        mm[0][0].wvalid = 1'b0; mm[0][0].wlast = 1'b0; mm[0][0].bready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ms[0][0].bvalid, ms[0][0].bid, ms[0][0].bresp} !== {1'b1, 4'd2, SLVERR}) begin
          fails++; $display("FAIL wr_bresp got v=%b id=%0d resp=%0d want 1 2 2", ms[0][0].bvalid, ms[0][0].bid, ms[0][0].bresp);
        end
        @(posedge clk); #1;
        mm[0][0].bready = 1'b0;
        @(negedge clk);
        checks++;
        if ({ms[0][0].bvalid, ms[0][0].awready} !== 2'b01) begin fails++; $display("FAIL wr_back_idle got %b want 01", {ms[0][0].bvalid, ms[0][0].awready}); end
        // m1 write with a random id and burst length, overlapping its own read
        mm[0][1].awid = wid; mm[0][1].awvalid = 1'b1;
        wait_sig(0, 1, 2, ok);
        @(posedge clk); #1;
        mm[0][1].awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
          mm[0][1].wvalid = 1'b1; mm[0][1].wlast = (b == nbeats - 1);
          wait_sig(0, 1, 3, ok);
          @(posedge clk); #1;
        end
        mm[0][1].wvalid = 1'b0; mm[0][1].wlast = 1'b0; mm[0][1].bready = 1'b1;
        wait_sig(0, 1, 4, ok);
        checks++;
        if ({ok, ms[0][1].bid, ms[0][1].bresp} !== {1'b1, wid, SLVERR}) begin
          fails++; $display("FAIL wr_m1_bresp got v=%b id=%0d resp=%0d want 1 %0d 2", ok, ms[0][1].bid, ms[0][1].bresp, wid);
        end
        @(posedge clk); #1;
        mm[0][1].bready = 1'b0;
      end
      begin
        rd(0, 1, a1, 4'd5, 8'd2, 1, t, n, d, ids, ls);
        checks++;
        if (n !== 3 || d[0] !== rom_word(a1) || d[2] !== rom_word(a1 + 8) || ids[2] !== 4'd5 || ls !== 8'b100) begin
          fails++; $display("FAIL wr_concurrent_read beats=%0d d0=%h d2=%h want 3 %h %h", n, d[0], d[2], rom_word(a1), rom_word(a1 + 8));
        end
      end
    join
    checks++;
    if (g_rom[0].leaks !== 0) begin fails++; $display("FAIL wr_no_leak got %0d want 0", g_rom[0].leaks); end
    ptr0 = 0;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a0, a1;
    int t, n, seen; logic [31:0] d [8]; logic [3:0] ids [8]; logic [7:0] ls;
    bit ok;
    a0 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    a1 = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    @(posedge clk); #1;
    mm[0][0].araddr = a0; mm[0][0].arid = 4'd7; mm[0][0].arlen = 8'd3; mm[0][0].arvalid = 1'b1; mm[0][0].rready = 1'b0;
    wait_sig(0, 0, 0, ok);
    @(posedge clk); #1;
    mm[0][0].arvalid = 1'b0;
    wait_sig(0, 0, 1, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL rstmid_rvalid_timeout got 0 want 1"); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ms[0][0].rvalid, ms[0][0].arready, ms[0][0].bvalid, ms[0][0].awready, ms[0][1].rvalid, ms[0][1].awready,
         sm[0].arvalid, sm[0].rready} !== 8'b0) begin
      fails++; $display("FAIL rstmid_drop got %b want 00000000", {ms[0][0].rvalid, ms[0][0].arready, ms[0][0].bvalid,
                        ms[0][0].awready, ms[0][1].rvalid, ms[0][1].awready, sm[0].arvalid, sm[0].rready});
    end
    mm[0][0].rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (ms[0][0].rvalid) seen++; end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL rstmid_no_replay got %0d beats want 0", seen); end
    mm[0][0].rready = 1'b0;
    rd(0, 1, a1, 4'd4, 8'd1, 0, t, n, d, ids, ls);
    checks++;
    if (n !== 2 || d[0] !== rom_word(a1) || d[1] !== rom_word(a1 + 4) || ids[1] !== 4'd4) begin
      fails++; $display("FAIL rstmid_m1_read beats=%0d d0=%h d1=%h want 2 %h %h", n, d[0], d[1], rom_word(a1), rom_word(a1 + 4));
    end
    ptr0 = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    int ths [4], trv [4];
    logic [31:0] dat [4];
    logic [3:0]  rid [4];
    int nr;
    bit ok;
    for (int i = 0; i < 4; i++) begin a[i] = {20'h0, 10'($urandom_range(0, 1023)), 2'b00}; ths[i] = -100; trv[i] = -100; end
    nr = 0;
    mm[0][0].rready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          mm[0][0].araddr = a[i]; mm[0][0].arid = 4'(i); mm[0][0].arlen = 8'd0; mm[0][0].arvalid = 1'b1;
          wait_sig(0, 0, 0, ok);
          if (ok) ths[i] = cyc;
        end
        @(posedge clk); #1;
        mm[0][0].arvalid = 1'b0;
      end
      begin
        for (int w = 0; w < 60 && nr < 4; w++) begin
          @(negedge clk);
          if (ms[0][0].rvalid) begin dat[nr] = ms[0][0].rdata; rid[nr] = ms[0][0].rid; trv[nr] = cyc; nr++; end
        end
      end
    join
    mm[0][0].rready = 1'b0;
    checks++;
    if (nr !== 4) begin fails++; $display("FAIL b2b_count got %0d want 4", nr); end
    for (int i = 0; i < nr; i++) begin
      checks++;
      if (dat[i] !== rom_word(a[i]) || rid[i] !== 4'(i) || trv[i] !== ths[i] + 1) begin
        fails++; $display("FAIL b2b_data beat%0d got d=%h id=%0d t=%0d want %h %0d %0d", i, dat[i], rid[i], trv[i], rom_word(a[i]), i, ths[i] + 1);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (ths[i] - ths[i-1] !== 3) begin fails++; $display("FAIL b2b_spacing txn%0d got %0d want 3", i, ths[i] - ths[i-1]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fast[k] = 1'b1;
      for (int m = 0; m < 2; m++) mm[k][m] = '0;
    end
    repeat (3) @(posedge clk);
    test_reset();
    test_basic_read();
    test_round_robin();
    test_rready_stall();
    test_write_error();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
